// File: rtl/fft_bitrev_reorder_pkg.sv
// rtl/fft_bitrev_reorder_pkg.sv - shared types and helpers for the bit-reversal reorder buffer
package fft_bitrev_reorder_pkg;

  localparam int BANK_W         = 1;
  localparam int DEF_DATA_WIDTH = 16;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] re;
    logic [DEF_DATA_WIDTH-1:0] im;
  } cplx_t;

  // Reverses the low 'width' bits of idx; higher result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = idx[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// rtl/fft_bitrev_reorder_if.sv - sample-in / handshake-out bundle for the reorder buffer
interface fft_bitrev_reorder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16
);
  localparam int LOG2N = $clog2(N_POINTS);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_re;
  logic [DATA_WIDTH-1:0] in_im;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_re;
  logic [DATA_WIDTH-1:0] out_im;
  logic [LOG2N-1:0]      out_idx;
  logic                  out_last;
  logic                  overflow;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  out_valid, out_re, out_im, out_idx, out_last, overflow
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output out_valid, out_re, out_im, out_idx, out_last, overflow
  );
endinterface

// File: rtl/fft_bitrev_reorder_dp_ram.sv
// rtl/fft_bitrev_reorder_dp_ram.sv - simple dual-port RAM with a resettable sync-read data register
module fft_bitrev_reorder_dp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Holds its value between reads so a stalled output stays stable.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong buffer turning bit-reversed FFT frames into natural order
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16
) (
  input logic                clk,
  input logic                rst,
  fft_bitrev_reorder_if.slave bus
);

  localparam int LOG2N  = $clog2(N_POINTS);
  localparam int ADDR_W = LOG2N + BANK_W;
  localparam int WORD_W = 2 * DATA_WIDTH;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  logic [LOG2N-1:0]  wr_cnt, rd_cnt, wr_idx;
  logic              wr_bank, rd_bank;
  logic [1:0]        bank_full, bank_full_nxt;
  logic              wr_en, rd_en, wr_wrap, rd_wrap;
  logic [WORD_W-1:0] rd_data;
  logic              out_valid_q, out_last_q, overflow_q;
  logic [LOG2N-1:0]  out_idx_q;

  // Full flags are registered, so a bank being written and one being read are never the same.
  assign wr_en   = bus.in_valid && !bank_full[wr_bank];
  assign rd_en   = bank_full[rd_bank] && (!out_valid_q || bus.out_ready);
  assign wr_wrap = wr_en && (wr_cnt == LAST_IDX);
  assign rd_wrap = rd_en && (rd_cnt == LAST_IDX);
  assign wr_idx  = LOG2N'(bitrev(32'(wr_cnt), LOG2N));

  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_wrap) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_wrap) bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      bank_full   <= 2'b00;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_wrap) wr_bank <= ~wr_bank;
      end
      if (bus.in_valid && bank_full[wr_bank]) overflow_q <= 1'b1;
      if (rd_en) begin
        rd_cnt      <= rd_cnt + 1'b1;
        if (rd_wrap) rd_bank <= ~rd_bank;
        out_valid_q <= 1'b1;
        out_idx_q   <= rd_cnt;
        out_last_q  <= (rd_cnt == LAST_IDX);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  fft_bitrev_reorder_dp_ram #(
    .WIDTH (WORD_W),
    .DEPTH (2 * N_POINTS),
    .AW    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data ({bus.in_re, bus.in_im}),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_cnt}),
    .rd_data (rd_data)
  );

  assign bus.out_re    = rd_data[WORD_W-1:DATA_WIDTH];
  assign bus.out_im    = rd_data[DATA_WIDTH-1:0];
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - self-checking bench for fft_bitrev_reorder
module tb_fft_bitrev_reorder;
  import fft_bitrev_reorder_pkg::*;

  localparam int DW = 16;
  localparam int N = 16;
  localparam int LOG2N = 4;

  typedef struct packed {
    logic [DW-1:0]    re;
    logic [DW-1:0]    im;
    logic [LOG2N-1:0] idx;
    logic             last;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.DATA_WIDTH(DW), .N_POINTS(N)) bus ();

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  obs_t  got_q[$];
  obs_t  exp_q[$];
  int    got_cyc[$];
  obs_t  mon_o;
  cplx_t fr[N];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      mon_o.re   = bus.out_re;
      mon_o.im   = bus.out_im;
      mon_o.idx  = bus.out_idx;
      mon_o.last = bus.out_last;
      got_q.push_back(mon_o);
      got_cyc.push_back(cyc);
    end
  end

  function automatic int brev4(input int i);
    return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    step();
    step();
    rst = 1'b0;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic gen_frame();
    for (int i = 0; i < N; i++) begin
      fr[i].re = DW'($urandom);
      fr[i].im = DW'($urandom);
    end
  endtask

  // Frame arrives with input position i holding frequency brev4(i).
  task automatic model_frame();
    cplx_t nat[N];
    obs_t o;
    for (int i = 0; i < N; i++) nat[brev4(i)] = fr[i];
    for (int k = 0; k < N; k++) begin
      o.re = nat[k].re;
      o.im = nat[k].im;
      o.idx = LOG2N'(k);
      o.last = (k == N - 1);
      exp_q.push_back(o);
    end
  endtask

  task automatic feed_frame(output int c_last);
    c_last = 0;
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_re = fr[i].re;
      bus.in_im = fr[i].im;
      if (i == N - 1) c_last = cyc;
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_count(input int n, input int bound);
    for (int i = 0; i < bound && got_q.size() < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_re = DW'($urandom);
    bus.in_im = DW'($urandom);
    bus.out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    n_cmp++; if (bus.out_idx !== '0) begin n_fail++; $display("FAIL reset_out_idx got %0d want 0", bus.out_idx); end
    n_cmp++; if (bus.out_re !== '0) begin n_fail++; $display("FAIL reset_out_re got %h want 0", bus.out_re); end
    n_cmp++; if (bus.out_im !== '0) begin n_fail++; $display("FAIL reset_out_im got %h want 0", bus.out_im); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    step();
    do_reset();
  endtask

  task automatic test_order();
    int c_last;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      fr[i].re = DW'(brev4(i));
      fr[i].im = ~(DW'(brev4(i)));
    end
    model_frame();
    feed_frame(c_last);
    wait_count(N, 60);
    n_cmp++; if (got_q.size() != N) begin n_fail++; $display("FAIL order_count got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL order[%0d] got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b", i,
                 got_q[i].re, got_q[i].im, got_q[i].idx, got_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].idx, exp_q[i].last);
      end
    end
    n_cmp++;
    if (got_cyc.size() == 0 || got_cyc[0] != c_last + 2) begin
      n_fail++;
      $display("FAIL order_latency got cycle %0d want %0d", (got_cyc.size() == 0) ? -1 : got_cyc[0], c_last + 2);
    end
  endtask

  task automatic test_streaming();
    int c_last;
    bit gap;
    do_reset();
    bus.out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      gen_frame();
      model_frame();
      feed_frame(c_last);
    end
    wait_count(3 * N, 100);
    n_cmp++; if (got_q.size() != 3 * N) begin n_fail++; $display("FAIL stream_count got %0d want %0d", got_q.size(), 3 * N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stream[%0d] got re=%h im=%h idx=%0d want re=%h im=%h idx=%0d", i,
                 got_q[i].re, got_q[i].im, got_q[i].idx, exp_q[i].re, exp_q[i].im, exp_q[i].idx);
      end
    end
    gap = 1'b0;
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[0] + i) gap = 1'b1;
    n_cmp++; if (gap) begin n_fail++; $display("FAIL stream_gap got gap=1 want 0"); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL stream_overflow got %b want 0", bus.overflow); end
  endtask

  task automatic test_backpressure();
    int c_last;
    do_reset();
    bus.out_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      gen_frame();
      model_frame();
      feed_frame(c_last);
    end
    gen_frame();
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_re = fr[i].re;
      bus.in_im = fr[i].im;
      if (i == 0) begin
        @(negedge clk);
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before got %b want 0", bus.overflow); end
      end
      if (i == 1) begin
        @(negedge clk);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after got %b want 1", bus.overflow); end
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_count(2 * N, 100);
    repeat (5) step();
    @(negedge clk);
    n_cmp++; if (got_q.size() != 2 * N) begin n_fail++; $display("FAIL bp_count got %0d want %0d", got_q.size(), 2 * N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp[%0d] got re=%h idx=%0d want re=%h idx=%0d", i, got_q[i].re, got_q[i].idx, exp_q[i].re, exp_q[i].idx);
      end
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got out_valid=%b want 0", bus.out_valid); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %b want 1", bus.overflow); end
  endtask

  task automatic test_stall_hold();
    bit   held;
    obs_t prev;
    bit   prev_v;
    do_reset();
    gen_frame();
    model_frame();
    held = 1'b0;
    for (int c = 0; c < 200 && got_q.size() < N; c++) begin
      bus.in_valid = (c < N);
      if (c < N) begin
        bus.in_re = fr[c].re;
        bus.in_im = fr[c].im;
      end
      bus.out_ready = (c % 3 == 0);
      @(negedge clk);
      if (held) begin
        n_cmp++;
        if (bus.out_valid !== prev_v || bus.out_re !== prev.re || bus.out_im !== prev.im || bus.out_idx !== prev.idx) begin
          n_fail++;
          $display("FAIL stall_hold got v=%b re=%h idx=%0d want v=%b re=%h idx=%0d",
                   bus.out_valid, bus.out_re, bus.out_idx, prev_v, prev.re, prev.idx);
        end
      end
      held = bus.out_valid && !bus.out_ready;
      prev_v = bus.out_valid;
      prev.re = bus.out_re;
      prev.im = bus.out_im;
      prev.idx = bus.out_idx;
      step();
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (got_q.size() != N) begin n_fail++; $display("FAIL stall_count got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall[%0d] got re=%h idx=%0d want re=%h idx=%0d", i, got_q[i].re, got_q[i].idx, exp_q[i].re, exp_q[i].idx);
      end
    end
  endtask

  task automatic test_reset_midop();
    int c_last;
    bit seen;
    do_reset();
    bus.out_ready = 1'b1;
    gen_frame();
    feed_frame(c_last);
    gen_frame();
    for (int j = 0; j < 7; j++) begin
      bus.in_valid = 1'b1;
      bus.in_re = fr[j].re;
      bus.in_im = fr[j].im;
      if (j == 6) begin
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 4'd5) begin
          n_fail++;
          $display("FAIL midop_drain got v=%b idx=%0d want v=1 idx=5", bus.out_valid, bus.out_idx);
        end
      end
      step();
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_idx !== '0 ||
        bus.out_re !== '0 || bus.out_im !== '0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_zero got v=%b l=%b idx=%0d re=%h im=%h ovf=%b want all 0",
               bus.out_valid, bus.out_last, bus.out_idx, bus.out_re, bus.out_im, bus.overflow);
    end
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    step();
    n_cmp++; if (seen) begin n_fail++; $display("FAIL midop_silent got out_valid=1 want 0"); end
    gen_frame();
    model_frame();
    feed_frame(c_last);
    wait_count(N, 60);
    n_cmp++; if (got_q.size() != N) begin n_fail++; $display("FAIL midop_count got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midop[%0d] got re=%h idx=%0d want re=%h idx=%0d", i, got_q[i].re, got_q[i].idx, exp_q[i].re, exp_q[i].idx);
      end
    end
  endtask

  task automatic test_bank_reuse();
    int c_last;
    do_reset();
    bus.out_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      gen_frame();
      model_frame();
      feed_frame(c_last);
    end
    bus.out_ready = 1'b1;
    repeat (15) step();
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_idx !== 4'd15) begin
      n_fail++;
      $display("FAIL reuse_last got v=%b last=%b idx=%0d want v=1 last=1 idx=15", bus.out_valid, bus.out_last, bus.out_idx);
    end
    gen_frame();
    model_frame();
    feed_frame(c_last);
    wait_count(3 * N, 150);
    n_cmp++; if (got_q.size() != 3 * N) begin n_fail++; $display("FAIL reuse_count got %0d want %0d", got_q.size(), 3 * N); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reuse[%0d] got re=%h idx=%0d want re=%h idx=%0d", i, got_q[i].re, got_q[i].idx, exp_q[i].re, exp_q[i].idx);
      end
    end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reuse_overflow got %b want 0", bus.overflow); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_order();
    test_streaming();
    test_backpressure();
    test_stall_hold();
    test_reset_midop();
    test_bank_reuse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
